// File: rtl/ram_arbiter_rr_if.sv
// rtl/ram_arbiter_rr_if.sv - requester, response and RAM-side signals of the round-robin RAM arbiter
interface ram_arbiter_rr_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req0;
   logic                  we0;
   logic                  lock0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] wdata0;
   logic                  ack0;
   logic                  rvalid0;
   logic [DATA_WIDTH-1:0] rdata0;

   logic                  req1;
   logic                  we1;
   logic                  lock1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  ack1;
   logic                  rvalid1;
   logic [DATA_WIDTH-1:0] rdata1;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  owner;

   // master: requesters plus the RAM's read port; slave: the arbiter
   modport master (
      output req0, we0, lock0, addr0, wdata0,
      output req1, we1, lock1, addr1, wdata1,
      output ram_rdata,
      input  ack0, rvalid0, rdata0,
      input  ack1, rvalid1, rdata1,
      input  ram_we, ram_addr, ram_wdata, owner
   );

   modport slave (
      input  req0, we0, lock0, addr0, wdata0,
      input  req1, we1, lock1, addr1, wdata1,
      input  ram_rdata,
      output ack0, rvalid0, rdata0,
      output ack1, rvalid1, rdata1,
      output ram_we, ram_addr, ram_wdata, owner
   );
endinterface

// File: rtl/ram_arbiter_rr.sv
// rtl/ram_arbiter_rr.sv - two-requester round-robin arbiter and sequencer for a single-port RAM
module ram_arbiter_rr #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic            clk,
   input  logic            rst,
   ram_arbiter_rr_if.slave bus
);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state, state_nx;
   logic                  prio, prio_nx;
   logic                  owner_q, owner_nx;
   logic [CW-1:0]         cnt, cnt_nx;

   logic                  grant_any;
   logic                  grant_id;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic                  ram_we_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [DATA_WIDTH-1:0] ram_wdata_q;
   logic                  rd_pend;
   logic                  rd_tag;
   logic                  rvalid0_q, rvalid1_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

   // Grant depends only on req, state, prio and owner; the lock of the
   // granted beat then steers the next state.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = owner_q;
      state_nx  = state;
      prio_nx   = prio;
      owner_nx  = owner_q;
      cnt_nx    = cnt;
      case (state)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               grant_any = 1'b1;
               grant_id  = prio;
            end else if (bus.req0) begin
               grant_any = 1'b1;
               grant_id  = 1'b0;
            end else if (bus.req1) begin
               grant_any = 1'b1;
               grant_id  = 1'b1;
            end
            if (grant_any) begin
               owner_nx = grant_id;
               if (grant_id ? bus.lock1 : bus.lock0) begin
                  state_nx = LOCKED;
                  cnt_nx   = CW'(1);
               end else begin
                  prio_nx = ~grant_id;
               end
            end
         end
         LOCKED: begin
            if (owner_q ? bus.req1 : bus.req0) begin
               grant_any = 1'b1;
               grant_id  = owner_q;
               cnt_nx    = cnt + CW'(1);
               if (!(owner_q ? bus.lock1 : bus.lock0) || cnt_nx == CW'(MAX_BURST)) begin
                  state_nx = IDLE;
                  prio_nx  = ~owner_q;
                  cnt_nx   = '0;
               end
            end else begin
               // owner let go without a beat: release and hand priority over
               state_nx = IDLE;
               prio_nx  = ~owner_q;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (rst) begin
         grant_any = 1'b0;
      end
   end

   always_comb begin
      sel_we    = grant_id ? bus.we1    : bus.we0;
      sel_addr  = grant_id ? bus.addr1  : bus.addr0;
      sel_wdata = grant_id ? bus.wdata1 : bus.wdata0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         prio    <= 1'b0;
         owner_q <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nx;
         prio    <= prio_nx;
         owner_q <= owner_nx;
         cnt     <= cnt_nx;
      end
   end

   // Command stage drives the RAM; the read stage samples its combinational
   // output one cycle later and returns it to the tagged requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_pend     <= 1'b0;
         rd_tag      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         ram_we_q <= grant_any & sel_we;
         if (grant_any) begin
            ram_addr_q  <= sel_addr;
            ram_wdata_q <= sel_wdata;
         end
         rd_pend   <= grant_any & ~sel_we;
         rd_tag    <= grant_id;
         rvalid0_q <= rd_pend & ~rd_tag;
         rvalid1_q <= rd_pend & rd_tag;
         if (rd_pend && !rd_tag) begin
            rdata0_q <= bus.ram_rdata;
         end
         if (rd_pend && rd_tag) begin
            rdata1_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.ack0      = grant_any & ~grant_id;
   assign bus.ack1      = grant_any & grant_id;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.owner     = owner_q;
endmodule

// File: tb/tb_ram_arbiter_rr.sv
// tb/tb_ram_arbiter_rr.sv - randomized scoreboard bench for ram_arbiter_rr with a RAM model
module tb_ram_arbiter_rr;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int MB = 16;

   typedef struct {
      int         due;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } cmd_t;

   typedef struct {
      int         due;
      logic [7:0] data;
   } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arbiter_rr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_arbiter_rr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [7:0] ram_mem [256] = '{default: 8'h00};
   logic [7:0] ref_mem [256] = '{default: 8'h00};

   always @(posedge clk) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
   end
   assign bus.ram_rdata = ram_mem[bus.ram_addr];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_t cmdq[$];
   rd_t  rq0[$];
   rd_t  rq1[$];

   // reference model state: who holds a lock (-1 none), beats taken, whose turn
   int         m_hold = -1;
   int         m_beats = 0;
   int         m_turn = 0;
   int         m_last = 0;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] m_wdata = 8'h00;
   logic       s_ack0, s_ack1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic r0, input logic w0, input logic l0,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [7:0] a1, input logic [7:0] d1);
      int         g;
      logic       lk;
      logic       sw;
      logic [7:0] sa, sd;
      bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1;
      #2;
      g = -1;
      if (m_hold < 0) begin
         if (r0 && r1) g = m_turn;
         else if (r0) g = 0;
         else if (r1) g = 1;
         if (g >= 0) begin
            lk = (g == 0) ? l0 : l1;
            if (lk) begin
               m_hold = g;
               m_beats = 1;
            end else begin
               m_turn = 1 - g;
            end
         end
      end else if ((m_hold == 0) ? r0 : r1) begin
         g = m_hold;
         m_beats++;
         lk = (g == 0) ? l0 : l1;
         if (!lk || m_beats == MB) begin
            m_turn = 1 - g;
            m_hold = -1;
            m_beats = 0;
         end
      end else begin
         m_turn = 1 - m_hold;
         m_hold = -1;
         m_beats = 0;
      end
      chk("ack0", bus.ack0, g == 0);
      chk("ack1", bus.ack1, g == 1);
      chk("owner", bus.owner, m_last);
      s_ack0 = bus.ack0;
      s_ack1 = bus.ack1;
      if (g >= 0) begin
         m_last = g;
         sw = (g == 0) ? w0 : w1;
         sa = (g == 0) ? a0 : a1;
         sd = (g == 0) ? d0 : d1;
         m_addr = sa;
         m_wdata = sd;
         cmdq.push_back('{cyc + 1, sw, sa, sd});
         if (sw) ref_mem[sa] = sd;
         else if (g == 0) rq0.push_back('{cyc + 2, ref_mem[sa]});
         else rq1.push_back('{cyc + 2, ref_mem[sa]});
      end else begin
         cmdq.push_back('{cyc + 1, 1'b0, m_addr, m_wdata});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic rand_step();
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 15)), 8'($urandom));
   endtask

   task automatic reset_dut();
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
      rst = 1'b1;
      cmdq.delete(); rq0.delete(); rq1.delete();
      m_hold = -1; m_beats = 0; m_turn = 0; m_last = 0; m_addr = 8'h00; m_wdata = 8'h00;
      #1;
      chk("rst_ack0", bus.ack0, 0);
      chk("rst_ack1", bus.ack1, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_ram_wdata", bus.ram_wdata, 0);
      chk("rst_rvalid0", bus.rvalid0, 0);
      chk("rst_rvalid1", bus.rvalid1, 0);
      chk("rst_rdata0", bus.rdata0, 0);
      chk("rst_rdata1", bus.rdata1, 0);
      chk("rst_owner", bus.owner, 0);
      @(posedge clk);
      #1;
      chk("rst_rvalid0_held", bus.rvalid0, 0);
      chk("rst_rvalid1_held", bus.rvalid1, 0);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      rst = 1'b0;
   endtask

   cmd_t c;
   rd_t  r;
   logic e0, e1;
   always @(negedge clk) begin
      if (!rst) begin
         if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
            c = cmdq.pop_front();
            chk("ram_we", bus.ram_we, c.we);
            chk("ram_addr", bus.ram_addr, c.addr);
            chk("ram_wdata", bus.ram_wdata, c.wdata);
         end
         e0 = rq0.size() > 0 && rq0[0].due == cyc;
         e1 = rq1.size() > 0 && rq1[0].due == cyc;
         chk("rvalid0", bus.rvalid0, e0);
         chk("rvalid1", bus.rvalid1, e1);
         if (e0) begin
            r = rq0.pop_front();
            chk("rdata0", bus.rdata0, r.data);
         end
         if (e1) begin
            r = rq1.pop_front();
            chk("rdata1", bus.rdata1, r.data);
         end
      end
   end

   initial begin
      int n0, n1;
      bus.req0 = 0; bus.we0 = 0; bus.lock0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
      bus.req1 = 0; bus.we1 = 0; bus.lock1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
      #6;
      reset_dut();

      step(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("tp_write_ack0", s_ack0, 1);
      step(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("tp_read_ack0", s_ack0, 1);
      repeat (3) idle();

      reset_dut();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
         chk("alt_ack0", s_ack0, (i % 2) == 0);
      end
      repeat (3) idle();

      reset_dut();
      n0 = 0;
      for (int i = 0; i < MB; i++) begin
         step(1'b1, 1'b0, 1'b1, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
         n0 += int'(s_ack0);
      end
      chk("burst_len", n0, MB);
      step(1'b1, 1'b0, 1'b1, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      chk("ack1_after_max_burst", s_ack1, 1);
      chk("owner_after_max_burst", bus.owner, 1);
      repeat (3) step(1'b1, 1'b0, 1'b1, 8'h31, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      repeat (3) idle();

      reset_dut();
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, i < 3, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
         n0 += int'(s_ack0);
         n1 += int'(s_ack1);
      end
      chk("short_burst_ack0", n0, 4);
      chk("short_burst_no_ack1", n1, 0);
      step(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
      chk("ack1_after_release", s_ack1, 1);
      repeat (3) idle();

      reset_dut();
      repeat (2) step(1'b1, 1'b0, 1'b1, 8'h06, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h06, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00);
      chk("drop_no_ack", {s_ack0, s_ack1}, 0);
      step(1'b1, 1'b0, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 8'h00);
      chk("drop_then_ack1", s_ack1, 1);
      repeat (3) idle();

      for (int i = 0; i < 2000; i++) rand_step();

      step(1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      reset_dut();
      step(1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
      chk("prio_after_reset", s_ack0, 1);

      for (int i = 0; i < 300; i++) rand_step();
      repeat (4) idle();
      #5;
      chk("queues_drained", cmdq.size() + rq0.size() + rq1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_arbiter_rr.md
# ram_arbiter_rr

Two-requester round-robin arbiter and sequencer for the single-port `ram_simple` memory. It accepts at most one access per cycle from either requester and drives the RAM's write enable, address and write data from registers. It returns read data to the requester that issued the read. An optional lock lets one requester hold the RAM for a bounded burst.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 8, RAM address width
- MAX_BURST, 16, maximum beats per locked burst (>=2); beat counter width is clog2(MAX_BURST+1)

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request
- we0 / we1  in  1  1 = write, 0 = read (qualified by req)
- addr0 / addr1  in  ADDR_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- lock0 / lock1  in  1  keep ownership after this beat
- ack0 / ack1  out  1  combinational; beat accepted this cycle
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse
- rdata0 / rdata1  out  DATA_WIDTH  read data, held until next rvalid for that requester
- ram_we  out  1  to RAM `we`, registered
- ram_addr  out  ADDR_WIDTH  to RAM `addr`, registered
- ram_wdata  out  DATA_WIDTH  to RAM `data_in`, registered
- ram_rdata  in  DATA_WIDTH  from RAM `data_out`; combinational read of mem[ram_addr]
- owner  out  1  requester index of the current or last grant

## Operation
- States:
  - IDLE: round-robin arbitration.
  - LOCKED: only `owner` may be acked.
- Registers:
  - `prio`: requester that wins a tie.
  - `cnt`: beats accepted in the current lock.
- IDLE arbitration:
  - Exactly one requester with req high is acked.
  - If both req are high, `prio` is acked.
  - After an ack to k, `prio` <= 1-k and `owner` <= k.
  - If the acked beat has lock=1: go to LOCKED, `cnt` <= 1, and `prio` is not updated.
- LOCKED, owner req=1:
  - ack owner; the other requester is never acked.
  - `cnt` <= `cnt`+1.
  - If lock=0, or if `cnt`+1 == MAX_BURST: go to IDLE, `prio` <= 1-owner, `cnt` <= 0.
- LOCKED, owner req=0: no ack this cycle; go to IDLE, `prio` <= 1-owner, `cnt` <= 0.
- Accepted beat in cycle N:
  - In N+1, ram_addr and ram_wdata hold the beat's addr and wdata, and ram_we = beat's we.
  - With no ack in N, ram_we=0 in N+1 and ram_addr/ram_wdata hold their previous value.
- Reads:
  - The arbiter tags a read with its requester index.
  - At the end of N+1 it samples ram_rdata into rdata<tag>.
  - rvalid<tag>=1 during N+2.
- Writes produce no rvalid.
- Ordering is strict issue order. A read issued the cycle after a write to the same address returns the new data.
- ack is a pure function of the req inputs, state, `prio` and `owner`. ack never depends on we/addr/wdata.

## Timing
- Throughput: one beat per cycle, back-to-back, any mix of requesters.
- Latency, ack to RAM command: 1 cycle.
- Latency, ack to rvalid for a read: 2 cycles.
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, prio=0, owner=0, cnt=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - rvalid0=rvalid1=0, rdata0=rdata1=0.
  - ack0=ack1=0 while rst=1.
- In-flight commands and reads are discarded on reset; no rvalid follows.
- Boundary cases:
  - Both req high with the same address: only one beat issues.
  - lock asserted while not granted: ignored.
  - A requester blocked by a lock is acked in the first IDLE cycle after release, because `prio` points to it.
  - `cnt` never exceeds MAX_BURST.

## Test plan
- Reset, then req0=1 we0=1 addr0=0x10 wdata0=0xA5 for 1 cycle; then req0=1 we0=0 addr0=0x10:
  - ack0 in both cycles.
  - ram_we=1 and ram_addr=0x10 one cycle after the first ack.
  - rvalid0=1 with rdata0=0xA5 two cycles after the second ack.
- req0 and req1 both held high with reads for 6 cycles from reset:
  - acks alternate 0,1,0,1,0,1.
  - rvalid0/rvalid1 alternate with the matching rdata, two cycles later.
- req0 with lock0=1 for 20 cycles, req1=1 throughout:
  - ack0 for exactly 16 cycles; then ack1 on the next cycle.
  - owner=1 afterward.
- req0 with lock0=1 for 3 beats, then lock0=0 on beat 4, req1 held high:
  - ack0 for 4 cycles, then ack1.
  - ack1 never asserts during the burst.
- Locked owner drops req0 for one cycle while req1=1:
  - no ack that cycle.
  - ack1 on the following cycle.
- Assert rst for one cycle while a read is 1 cycle from rvalid:
  - rvalid stays 0.
  - all RAM outputs and rdata are 0.
  - arbitration restarts with prio=0.
